// File: rtl/serial_byte_tx.sv
// serial_byte_tx: valid/ready byte to LSB-first serial frame with one-entry holding register
module serial_byte_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       busy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n, hold, hold_n;
  logic hold_full, hold_full_n, par, par_n, out_n;
  logic last, frame_end, accept, load_new;
  assign in_ready = !hold_full;
  always_comb begin
    last = cnt == CW'(CLKS_PER_BIT - 1);
    frame_end = state == STOP && last && bit_idx == 3'(STOP_BITS - 1);
    accept = in_valid && !hold_full;
    load_new = accept && (state == IDLE || (frame_end && !hold_full));
    state_n = state;
    cnt_n = last ? '0 : cnt + CW'(1);
    bit_n = bit_idx;
    shift_n = shift;
    hold_n = hold;
    hold_full_n = hold_full;
    par_n = par;
    case (state)
      IDLE: cnt_n = '0;
      START: if (last) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          state_n = PARITY_EN != 0 ? PARITY : STOP;
          bit_n = '0;
        end
      end
      PARITY: if (last) state_n = STOP;
      STOP: if (last) begin
        bit_n = bit_idx + 3'd1;
        if (frame_end) begin
          state_n = IDLE;
          bit_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // A frame ending with the holding register full chains straight into the next start bit
    if (frame_end && hold_full) begin
      state_n = START;
      shift_n = hold;
      par_n = ^hold ^ (PARITY_ODD != 0);
      hold_full_n = 1'b0;
    end else if (load_new) begin
      state_n = START;
      shift_n = in_byte;
      par_n = ^in_byte ^ (PARITY_ODD != 0);
      cnt_n = '0;
      bit_n = '0;
    end else if (accept) begin
      hold_n = in_byte;
      hold_full_n = 1'b1;
    end
    out_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      par <= 1'b0;
      out <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      hold <= hold_n;
      hold_full <= hold_full_n;
      par <= par_n;
      out <= out_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_serial_byte_tx.sv
// tb_serial_byte_tx: directed checks of serial_byte_tx in four parameter configurations
module tb_serial_byte_tx;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] in_byte;
  logic [3:0] valid, ready, out, busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_byte_tx u_def (.clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(valid[0]),
    .in_ready(ready[0]), .out(out[0]), .busy(busy[0]));
  serial_byte_tx #(.PARITY_EN(1)) u_pe (.clk(clk), .reset(reset), .in_byte(in_byte),
    .in_valid(valid[1]), .in_ready(ready[1]), .out(out[1]), .busy(busy[1]));
  serial_byte_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (.clk(clk), .reset(reset), .in_byte(in_byte),
    .in_valid(valid[2]), .in_ready(ready[2]), .out(out[2]), .busy(busy[2]));
  serial_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_slow (.clk(clk), .reset(reset), .in_byte(in_byte),
    .in_valid(valid[3]), .in_ready(ready[3]), .out(out[3]), .busy(busy[3]));
  task automatic test_reset();
    reset = 1'b1;
    valid = '0;
    in_byte = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 4'hF || busy !== 4'h0 || ready !== 4'hF) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: out=%b busy=%b ready=%b, want 1111 0000 1111", i, out, busy, ready);
      end
    end
  endtask
  task automatic test_default();
    logic [9:0] exp;
    logic [7:0] rx;
    exp = 10'b1101001010;
    rx = '0;
    in_byte = 8'hA5;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    in_byte = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 8) rx[i-1] = out[0];
      checks++;
      if (out[0] !== (i < 10 ? exp[i] : 1'b1)) begin
        errors++;
        $display("FAIL default_out cycle %0d: got %b want %b", i, out[0], i < 10 ? exp[i] : 1'b1);
      end
      checks++;
      if (busy[0] !== (i < 10)) begin
        errors++;
        $display("FAIL default_busy cycle %0d: got %b want %b", i, busy[0], i < 10);
      end
    end
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("FAIL default_rx: got %h want a5", rx);
    end
  endtask
  task automatic test_back_to_back();
    logic [19:0] fr;
    logic [7:0] rx1, rx2;
    logic eo, er, eb;
    fr = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0};
    rx1 = '0;
    rx2 = '0;
    for (int k = 0; k < 22; k++) begin
      if (k == 0) begin in_byte = 8'h3C; valid[0] = 1'b1; end
      if (k == 3) begin in_byte = 8'hFF; valid[0] = 1'b1; end
      @(posedge clk);
      #1 valid[0] = 1'b0;
      @(negedge clk);
      if (k >= 1 && k <= 8) rx1[k-1] = out[0];
      if (k >= 11 && k <= 18) rx2[k-11] = out[0];
      eo = k < 20 ? fr[k] : 1'b1;
      er = !(k >= 3 && k <= 9);
      eb = k < 20;
      checks++;
      if (out[0] !== eo) begin
        errors++;
        $display("FAIL b2b_out cycle %0d: got %b want %b", k, out[0], eo);
      end
      checks++;
      if (ready[0] !== er) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d: got %b want %b", k, ready[0], er);
      end
      checks++;
      if (busy[0] !== eb) begin
        errors++;
        $display("FAIL b2b_busy cycle %0d: got %b want %b", k, busy[0], eb);
      end
    end
    checks++;
    if (rx1 !== 8'h3C || rx2 !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_rx: got %h %h want 3c ff", rx1, rx2);
    end
  endtask
  task automatic test_parity();
    logic [10:0] pe, po;
    pe = 11'b11000001110;
    po = 11'b10000001110;
    in_byte = 8'h07;
    valid[2:1] = 2'b11;
    @(posedge clk);
    #1 valid[2:1] = 2'b00;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++;
      if (out[1] !== (i < 11 ? pe[i] : 1'b1)) begin
        errors++;
        $display("FAIL parity_even_out cycle %0d: got %b want %b", i, out[1], i < 11 ? pe[i] : 1'b1);
      end
      checks++;
      if (out[2] !== (i < 11 ? po[i] : 1'b1)) begin
        errors++;
        $display("FAIL parity_odd_out cycle %0d: got %b want %b", i, out[2], i < 11 ? po[i] : 1'b1);
      end
      checks++;
      if (busy[2:1] !== (i < 11 ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL parity_busy cycle %0d: got %b want %b", i, busy[2:1], i < 11 ? 2'b11 : 2'b00);
      end
    end
  endtask
  task automatic test_slow();
    in_byte = 8'h80;
    valid[3] = 1'b1;
    @(posedge clk);
    #1 valid[3] = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (out[3] !== (i >= 32)) begin
        errors++;
        $display("FAIL slow_out cycle %0d: got %b want %b", i, out[3], i >= 32);
      end
      checks++;
      if (busy[3] !== (i < 44)) begin
        errors++;
        $display("FAIL slow_busy cycle %0d: got %b want %b", i, busy[3], i < 44);
      end
    end
  endtask
  task automatic test_reset_mid();
    in_byte = 8'h55;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 in_byte = 8'h81;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: ready=%b busy=%b want 0 1", ready[0], busy[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3: got %b want 0", out[0]);
    end
    reset = 1'b1;
    in_byte = 8'h42;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    valid[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL mid_after_reset cycle %0d: out=%b busy=%b ready=%b want 1 0 1", i, out[0], busy[0], ready[0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_default();
    test_back_to_back();
    test_parity();
    test_slow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
